record_stream_packer: RTL and testbench
=======================================

Name: record_stream_packer

Overview:
- Sits directly downstream of the per-channel record unit.
- Captures each completed 32-bit record word on the rising edge of the record unit's data-valid level.
- Buffers captured words in a small first-word-fall-through (FWFT) FIFO and presents them as an AXI4-Stream master to the DMA/interconnect.
- Groups words into packets of fixed length with TLAST; a flush input can close a packet early.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- WORDS_PER_PKT, 8, words per packet before TLAST is forced; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; when low, no new words are captured, but draining continues.
- wordIn  in  32  record word from the upstream record unit.
- wordValid  in  1  level from the upstream record unit; a 0->1 transition means wordIn holds a new word.
- flush  in  1  single-cycle pulse; closes the current packet early.
- overflowClear  in  1  pulse; clears overflow and dropCount.
- m_axis_tdata  out  32  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  last beat of a packet.
- m_axis_tready  in  1  downstream ready.
- fifoCount  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a word is dropped.
- dropCount  out  16  dropped-word count; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - all outputs are 0; FIFO is empty; all internal counters and flags are 0.
  - the wordValid edge register is 0, so a wordValid already high when reset releases is captured on the first cycle.
- Capture:
  - capture = enable & wordValid & !wordValid_d, where wordValid_d is wordValid registered one cycle.
  - A word is captured in the cycle the edge is seen and appears in fifoCount on the next cycle.
  - A wordValid level held high produces exactly one capture.
- Push/pop:
  - pop = tvalid & tready.
  - push is accepted if fifoCount < DEPTH, or if fifoCount == DEPTH and pop occurs in the same cycle.
  - Otherwise the word is dropped: overflow <= 1 and dropCount increments (saturating).
  - Simultaneous push and pop leaves fifoCount unchanged.
- Output (FWFT):
  - tvalid = (fifoCount != 0); tdata and tlast come from the head entry.
  - Latency: a capture edge in cycle N gives tvalid high in cycle N+1.
  - While tvalid & !tready, tdata and tlast hold stable.
- TLAST tagging, decided at push time (each entry stores a tag bit):
  - pushCnt counts accepted pushes in the current packet.
  - A pushed word is tagged last if pushCnt == WORDS_PER_PKT-1, or if flushPending is set, or if flush is asserted in the same cycle.
  - After a tagged push, pushCnt <= 0 and flushPending <= 0.
  - Dropped words do not advance pushCnt.
- Flush without a coincident push:
  - If pushCnt == 0: ignored (no packet is open).
  - Else, if the newest entry is still in the FIFO and is not being popped this cycle: set that entry's tag bit and set pushCnt <= 0.
  - Else (FIFO empty, or the only entry is being popped this cycle): set flushPending, so the next accepted push is tagged.
- Overflow clear:
  - overflowClear clears overflow and dropCount.
  - A drop in the same cycle wins: overflow = 1, dropCount = 1.
- Wrap-around:
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.
  - fifoCount is tracked separately to distinguish full from empty.
- enable low:
  - Captures stop; the FIFO drains normally.
  - pushCnt and flushPending are preserved.
- Reset mid-packet: the FIFO contents are discarded; the partial packet is not closed.

Test Plan:
1. Capture/latency: with enable=1 and tready=1, drive 8 wordValid pulses with words 0x1..0x8 -> 8 beats in order; tvalid rises 1 cycle after each edge; tlast only on 0x8; a held-high wordValid yields a single word.
2. Backpressure/full: with tready=0 and DEPTH=16, push 18 words -> fifoCount=16, overflow=1, dropCount=2. Then raise tready -> 16 beats, with tlast on beats 8 and 16. overflowClear -> both cleared.
3. Full with simultaneous pop: at fifoCount=16, push and pop in the same cycle -> word accepted, fifoCount stays 16, no drop.
4. Flush cases:
   - After 3 words buffered, flush -> word 3 carries tlast; the next packet's tlast is on its 8th word.
   - Flush with the FIFO empty and pushCnt=2 -> the next pushed word carries tlast.
   - Flush with no open packet -> no effect.
5. Stall stability: hold tready=0 for 5 cycles with tvalid=1 -> tdata and tlast unchanged. Also toggle enable=0 mid-stream -> no captures, FIFO still drains.
6. Reset mid-operation: with 5 words buffered and pushCnt=5, assert reset for 1 cycle -> tvalid=0, fifoCount=0, overflow=0; the next packet's tlast falls on its 8th word.

Source files
------------

// File: rtl/record_stream_packer.sv
// Captures record words on wordValid rising edges into an FWFT FIFO and streams
// them out as AXI4-Stream packets of WORDS_PER_PKT beats, with early close on flush.
module record_stream_packer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned WORDS_PER_PKT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [31:0]              wordIn,
  input  logic                     wordValid,
  input  logic                     flush,
  input  logic                     overflowClear,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     overflow,
  output logic [15:0]              dropCount
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned PCW  = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
  localparam int unsigned DW   = 32;
  localparam int unsigned DCW  = 16;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0] tag_q, tag_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [PCW-1:0]  push_cnt_q, push_cnt_d;
  logic            flush_pend_q, flush_pend_d;
  logic            wv_q, wv_d;
  logic            ov_q, ov_d;
  logic [DCW-1:0]  drop_q, drop_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic [DW-1:0]   tdata_q, tdata_d;

  logic            capture;
  logic            pop;
  logic            full;
  logic            push;
  logic            drop;
  logic            tag_push;
  logic            tail_popping;
  logic [PW-1:0]   last_idx;

  // Next-state logic for pointers, packet tagging, overflow and output staging.
  always_comb begin
    capture      = enable & wordValid & ~wv_q;
    pop          = tvalid_q & m_axis_tready;
    full         = (count_q == CNTW'(DEPTH));
    push         = capture & (~full | pop);
    drop         = capture & ~push;
    tag_push     = (push_cnt_q == PCW'(WORDS_PER_PKT - 1)) | flush_pend_q | flush;
    tail_popping = pop & (count_q == CNTW'(1));
    last_idx     = wr_ptr_q - PW'(1);

    wv_d         = wordValid;
    tag_d        = tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    push_cnt_d   = push_cnt_q;
    flush_pend_d = flush_pend_q;
    ov_d         = ov_q;
    drop_d       = drop_q;
    tvalid_d     = 1'b0;
    tlast_d      = 1'b0;
    tdata_d      = '0;

    if (push) begin
      tag_d[wr_ptr_q] = tag_push;
      wr_ptr_d        = wr_ptr_q + PW'(1);
      if (tag_push) begin
        push_cnt_d   = '0;
        flush_pend_d = 1'b0;
      end else begin
        push_cnt_d = push_cnt_q + PCW'(1);
      end
    end else if (flush && (push_cnt_q != '0)) begin
      // Retag the newest buffered word unless it is leaving this cycle.
      if ((count_q != '0) && !tail_popping) begin
        tag_d[last_idx] = 1'b1;
        push_cnt_d      = '0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNTW'(1);
    end

    if (drop) begin
      ov_d = 1'b1;
      if (overflowClear) begin
        drop_d = DCW'(1);
      end else if (drop_q != {DCW{1'b1}}) begin
        drop_d = drop_q + DCW'(1);
      end
    end else if (overflowClear) begin
      ov_d   = 1'b0;
      drop_d = '0;
    end

    // Stage next head; a word pushed into an emptying FIFO bypasses the array.
    tvalid_d = (count_d != '0);
    if (tvalid_d) begin
      tlast_d = tag_d[rd_ptr_d];
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        tdata_d = wordIn;
      end else begin
        tdata_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      push_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
      wv_q         <= 1'b0;
      ov_q         <= 1'b0;
      drop_q       <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
    end else begin
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      push_cnt_q   <= push_cnt_d;
      flush_pend_q <= flush_pend_d;
      wv_q         <= wv_d;
      ov_q         <= ov_d;
      drop_q       <= drop_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= wordIn;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign fifoCount     = count_q;
  assign overflow      = ov_q;
  assign dropCount     = drop_q;

endmodule

// File: tb/tb_record_stream_packer.sv
// Scoreboard bench for record_stream_packer: expected beats are queued as words are
// driven and checked against every accepted AXI-Stream beat.
module tb_record_stream_packer;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] wordIn = '0;
  logic        wordValid = 1'b0;
  logic        flush = 1'b0;
  logic        overflowClear = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [4:0]  fifoCount;
  logic        overflow;
  logic [15:0] dropCount;

  beat_t exp_q[$];
  beat_t mon_e;
  beat_t tmp_b;
  int    total = 0;
  int    bad   = 0;

  record_stream_packer #(.DEPTH(16), .WORDS_PER_PKT(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wordIn(wordIn), .wordValid(wordValid),
    .flush(flush), .overflowClear(overflowClear), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .fifoCount(fifoCount), .overflow(overflow), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  // Every handshake predicted for the next rising edge is checked against the queue head.
  always @(negedge clk) begin
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got data=%h last=%b, required no beat", m_axis_tdata, m_axis_tlast);
      end else begin
        mon_e = exp_q.pop_front();
        if ({m_axis_tdata, m_axis_tlast} !== mon_e) begin
          bad++;
          $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                   m_axis_tdata, m_axis_tlast, mon_e.data, mon_e.last);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_word(input logic [31:0] d, input logic fl, input logic clr);
    wordIn = d; wordValid = 1'b1; flush = fl; overflowClear = clr;
    cyc(1);
    wordValid = 1'b0; flush = 1'b0; overflowClear = 1'b0;
    cyc(1);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    exp_q.push_back({d, last});
    pulse_word(d, 1'b0, 1'b0);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; wordValid = 1'b0; flush = 1'b0;
    overflowClear = 1'b0; m_axis_tready = 1'b0;
    cyc(2);
    exp_q.delete();
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || fifoCount != 0) && n < 300) begin
      cyc(1);
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL drain_timeout: got pending=%0d count=%0d, required 0", exp_q.size(), fifoCount);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; m_axis_tready = 1'b0; enable = 1'b1;
    wordIn = 32'h55; wordValid = 1'b1;
    cyc(2);
    total++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 34'h0) begin
      bad++;
      $display("FAIL reset_stream: got v=%b l=%b d=%h, required 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    total++;
    if ({fifoCount, overflow, dropCount} !== 22'h0) begin
      bad++;
      $display("FAIL reset_status: got cnt=%0d ov=%b drop=%0d, required 0", fifoCount, overflow, dropCount);
    end
    exp_q.delete();
    exp_q.push_back({32'h55, 1'b0});
    reset = 1'b0;
    cyc(1);
    total++;
    if (fifoCount !== 5'd1 || m_axis_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL reset_held_valid: got cnt=%0d v=%b, required cnt=1 v=1", fifoCount, m_axis_tvalid);
    end
    wordValid = 1'b0;
    m_axis_tready = 1'b1;
    wait_drain();
  endtask

  task automatic test_capture();
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back({32'(i), i == 8});
      wordIn = 32'(i); wordValid = 1'b1;
      total++;
      if (m_axis_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL latency_pre %0d: got v=%b, required 0", i, m_axis_tvalid);
      end
      cyc(1);
      total++;
      if (m_axis_tvalid !== 1'b1) begin
        bad++;
        $display("FAIL latency_post %0d: got v=%b, required 1", i, m_axis_tvalid);
      end
      wordValid = 1'b0;
      cyc(1);
    end
    exp_q.push_back({32'h9, 1'b0});
    wordIn = 32'h9; wordValid = 1'b1;
    cyc(1);
    wordIn = 32'hA;
    cyc(4);
    wordValid = 1'b0;
    cyc(1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_q.push_back({32'h100 + 32'(i), (i == 7) || (i == 15)});
      pulse_word(32'h100 + 32'(i), 1'b0, 1'b0);
    end
    total++;
    if (fifoCount !== 5'd16 || overflow !== 1'b1 || dropCount !== 16'd2) begin
      bad++;
      $display("FAIL full_status: got cnt=%0d ov=%b drop=%0d, required 16 1 2", fifoCount, overflow, dropCount);
    end
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h100 || m_axis_tlast !== 1'b0) begin
      bad++;
      $display("FAIL full_head: got v=%b d=%h l=%b, required 1 100 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    m_axis_tready = 1'b1;
    wait_drain();
    m_axis_tready = 1'b0;
    total++;
    if (overflow !== 1'b1 || dropCount !== 16'd2) begin
      bad++;
      $display("FAIL sticky_overflow: got ov=%b drop=%0d, required 1 2", overflow, dropCount);
    end
    overflowClear = 1'b1;
    cyc(1);
    overflowClear = 1'b0;
    total++;
    if (overflow !== 1'b0 || dropCount !== 16'd0) begin
      bad++;
      $display("FAIL overflow_clear: got ov=%b drop=%0d, required 0 0", overflow, dropCount);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back({32'h200 + 32'(i), (i == 7) || (i == 15)});
      pulse_word(32'h200 + 32'(i), 1'b0, 1'b0);
    end
    pulse_word(32'h2F0, 1'b0, 1'b0);
    pulse_word(32'h2F1, 1'b0, 1'b1);
    total++;
    if (overflow !== 1'b1 || dropCount !== 16'd1) begin
      bad++;
      $display("FAIL drop_beats_clear: got ov=%b drop=%0d, required 1 1", overflow, dropCount);
    end
    overflowClear = 1'b1;
    cyc(1);
    overflowClear = 1'b0;
    exp_q.push_back({32'h300, 1'b0});
    wordIn = 32'h300; wordValid = 1'b1; m_axis_tready = 1'b1;
    cyc(1);
    wordValid = 1'b0; m_axis_tready = 1'b0;
    total++;
    if (fifoCount !== 5'd16 || overflow !== 1'b0 || dropCount !== 16'd0) begin
      bad++;
      $display("FAIL full_push_pop: got cnt=%0d ov=%b drop=%0d, required 16 0 0", fifoCount, overflow, dropCount);
    end
    cyc(1);
    m_axis_tready = 1'b1;
    wait_drain();
  endtask

  task automatic test_flush();
    // Flush with words buffered retags the newest one.
    do_reset();
    send(32'h401, 1'b0);
    send(32'h402, 1'b0);
    send(32'h403, 1'b0);
    flush_pulse();
    tmp_b = exp_q.pop_back();
    tmp_b.last = 1'b1;
    exp_q.push_back(tmp_b);
    for (int i = 0; i < 8; i++) send(32'h410 + 32'(i), i == 7);
    m_axis_tready = 1'b1;
    wait_drain();
    // Flush with empty FIFO and an open packet tags the next word.
    do_reset();
    m_axis_tready = 1'b1;
    send(32'h501, 1'b0);
    send(32'h502, 1'b0);
    wait_drain();
    flush_pulse();
    send(32'h503, 1'b1);
    for (int i = 0; i < 8; i++) send(32'h510 + 32'(i), i == 7);
    wait_drain();
    // Flush with no open packet is ignored; flush alongside a push tags that word.
    do_reset();
    m_axis_tready = 1'b1;
    flush_pulse();
    for (int i = 0; i < 8; i++) send(32'h600 + 32'(i), i == 7);
    exp_q.push_back({32'h610, 1'b1});
    pulse_word(32'h610, 1'b1, 1'b0);
    send(32'h611, 1'b0);
    wait_drain();
    // Flush while the only entry is leaving defers the tag to the next word.
    do_reset();
    send(32'h701, 1'b0);
    m_axis_tready = 1'b1; flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    cyc(1);
    send(32'h702, 1'b1);
    send(32'h703, 1'b0);
    wait_drain();
  endtask

  task automatic test_stall();
    do_reset();
    exp_q.push_back({32'h801, 1'b1});
    pulse_word(32'h801, 1'b1, 1'b0);
    send(32'h802, 1'b0);
    send(32'h803, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h801 || m_axis_tlast !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold %0d: got v=%b d=%h l=%b, required 1 801 1",
                 i, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
      end
    end
    m_axis_tready = 1'b1;
    enable = 1'b0;
    pulse_word(32'h8AA, 1'b0, 1'b0);
    pulse_word(32'h8BB, 1'b0, 1'b0);
    wait_drain();
    total++;
    if (fifoCount !== 5'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL enable_low: got cnt=%0d ov=%b, required 0 0", fifoCount, overflow);
    end
    enable = 1'b1;
    for (int i = 0; i < 6; i++) send(32'h810 + 32'(i), i == 5);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 5; i++) send(32'h900 + 32'(i), 1'b0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    exp_q.delete();
    total++;
    if (m_axis_tvalid !== 1'b0 || fifoCount !== 5'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got v=%b cnt=%0d ov=%b, required 0 0 0", m_axis_tvalid, fifoCount, overflow);
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h910 + 32'(i), i == 7);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_backpressure();
    test_full_pop();
    test_flush();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
